// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Time-multiplexed debounce controller for the front-panel buttons. A slow
//   sample tick starts one scan pass; the pass walks channels 0..NUM_CH-1, one
//   per clock, through a single history-evaluation datapath. Debounced level
//   changes become pending events that a round-robin arbiter feeds into a
//   valid/ready output register.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   buttons      raw asynchronous button levels (NUM_CH bits)
//   debounced    debounced button levels (NUM_CH bits)
//   ev_valid     an event is presented on ev_ch / ev_rise
//   ev_ready     consumer accepts the presented event
//   ev_ch        channel of the presented event
//   ev_rise      1 = press (0->1), 0 = release (1->0)
//   ev_overflow  one-cycle pulse: an unconsumed pending event was overwritten
module debounce_scheduler #(
    parameter int NUM_CH   = 3,
    parameter int HIST_LEN = 8,
    parameter int TICK_DIV = 1000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] debounced,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CH_W-1:0]   ev_ch,
    output logic              ev_rise,
    output logic              ev_overflow
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    logic [NUM_CH-1:0]   sync1_reg, sync2_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                tick;
    state_t              state_reg, state_next;
    logic [CH_W-1:0]     idx_reg, idx_next;
    logic                scan_en;
    logic [NUM_CH-1:0]   scan_sel;

    // Only the most recent HIST_LEN-1 samples are stored: together with the
    // sample being scanned they form the full HIST_LEN-deep window, and the
    // oldest bit would be shifted out on the next scan anyway.
    logic [HIST_LEN-2:0] hist_reg [NUM_CH];
    logic [HIST_LEN-1:0] hist_new;
    logic                post_en, post_rise;

    logic [NUM_CH-1:0]   deb_reg, deb_next;
    logic [NUM_CH-1:0]   pend_reg, pend_next;
    logic [NUM_CH-1:0]   ptype_reg, ptype_next;
    logic                ovf_reg, ovf_next;

    logic [CH_W-1:0]     rr_reg, gnt_ch, cand_idx;
    int                  cand;
    logic                gnt_any, out_free, grant;
    logic                valid_reg, rise_reg;
    logic [CH_W-1:0]     ch_reg;

    // Two-flop synchronizer per button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= buttons;
            sync2_reg <= sync1_reg;
        end
    end

    // Sample-tick prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else if (cnt_reg == CNT_MAX)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = (cnt_reg == CNT_MAX);

    // Scan FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Scan FSM: next state. TICK_DIV > NUM_CH+1 guarantees a pass finishes
    // before the next tick, so ticks are only observed in IDLE.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        scan_en    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (tick) begin
                    state_next = S_SCAN;
                    idx_next   = '0;
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (idx_reg == LAST_CH) begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Per-channel write select for the history bank.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sel
            assign scan_sel[gi] = scan_en && (idx_reg == CH_W'(gi));
        end
    endgenerate

    // Shared evaluation datapath for the channel under scan.
    assign hist_new  = {hist_reg[idx_reg], sync2_reg[idx_reg]};
    assign post_rise = &hist_new;
    assign post_en   = scan_en &&
                       (( (&hist_new) && !deb_reg[idx_reg]) ||
                        (!(|hist_new) &&  deb_reg[idx_reg]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++)
                hist_reg[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (scan_sel[c])
                    hist_reg[c] <= hist_new[HIST_LEN-2:0];
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_ch   = rr_reg;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand     = (int'(rr_reg) + k) % NUM_CH;
            cand_idx = CH_W'(cand);
            if (!gnt_any && pend_reg[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = cand_idx;
            end
        end
    end

    assign out_free = !valid_reg || ev_ready;
    assign grant    = out_free && gnt_any;

    // Pending-event bookkeeping. The grant clears first so that a post to the
    // channel being granted in the same cycle re-arms it without an overflow.
    always_comb begin
        deb_next   = deb_reg;
        pend_next  = pend_reg;
        ptype_next = ptype_reg;
        ovf_next   = 1'b0;
        if (grant)
            pend_next[gnt_ch] = 1'b0;
        if (post_en) begin
            deb_next[idx_reg]   = post_rise;
            pend_next[idx_reg]  = 1'b1;
            ptype_next[idx_reg] = post_rise;
            ovf_next            = pend_reg[idx_reg] && !(grant && (gnt_ch == idx_reg));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_reg   <= '0;
            pend_reg  <= '0;
            ptype_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            deb_reg   <= deb_next;
            pend_reg  <= pend_next;
            ptype_reg <= ptype_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Output register: loads a new event whenever the slot is empty or the
    // current event is being accepted; holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            ch_reg    <= '0;
            rise_reg  <= 1'b0;
            rr_reg    <= LAST_CH;
        end else if (out_free) begin
            if (gnt_any) begin
                valid_reg <= 1'b1;
                ch_reg    <= gnt_ch;
                rise_reg  <= ptype_reg[gnt_ch];
                rr_reg    <= gnt_ch;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign debounced   = deb_reg;
    assign ev_valid    = valid_reg;
    assign ev_ch       = ch_reg;
    assign ev_rise     = rise_reg;
    assign ev_overflow = ovf_reg;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler
//   Directed and randomized bench for debounce_scheduler with NUM_CH=3,
//   HIST_LEN=4, TICK_DIV=8. Buttons only change mid tick period, so each tick
//   samples a well-defined value. A tick-level reference model (run length of
//   equal samples per channel) predicts debounced levels and the event stream.
module tb_debounce_scheduler;

    localparam int NUM_CH   = 3;
    localparam int HIST_LEN = 4;
    localparam int TICK_DIV = 8;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] buttons = '0;
    logic              ev_ready = 1'b0;
    logic [NUM_CH-1:0] debounced;
    logic              ev_valid;
    logic [CH_W-1:0]   ev_ch;
    logic              ev_rise;
    logic              ev_overflow;

    always #5 clk = ~clk;

    debounce_scheduler #(
        .NUM_CH   (NUM_CH),
        .HIST_LEN (HIST_LEN),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buttons     (buttons),
        .debounced   (debounced),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_rise     (ev_rise),
        .ev_overflow (ev_overflow)
    );

    typedef struct {
        int ch;
        int rise;
        int pc;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  pc = 0;            // posedges since the last reset release
    int  ovf_cnt = 0;
    int  valid_cycles = 0;
    bit  rand_ready = 1'b0;

    // Reference model state.
    int  run_len [NUM_CH];
    bit  last_s  [NUM_CH];
    bit  level   [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_levels();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = level[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            run_len[c] = HIST_LEN;   // history resets to all zeros
            last_s[c]  = 1'b0;
            level[c]   = 1'b0;
        end
    endtask

    // One sample tick: a level changes once HIST_LEN equal samples are seen.
    task automatic model_tick();
        ev_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            if (buttons[c] == last_s[c]) begin
                if (run_len[c] < HIST_LEN) run_len[c]++;
            end else begin
                run_len[c] = 1;
                last_s[c]  = buttons[c];
            end
            if (run_len[c] >= HIST_LEN && level[c] != last_s[c]) begin
                level[c] = last_s[c];
                e.ch = c; e.rise = int'(last_s[c]); e.pc = pc;
                exp_q.push_back(e);
            end
        end
    endtask

    // Advance one clock; called at a negedge. Logs transfers and overflow
    // pulses, runs the model on each tick and checks levels mid-period.
    task automatic step();
        ev_t e;
        if (rand_ready) ev_ready = ($urandom_range(0, 3) != 0);
        if (ev_valid && ev_ready) begin
            e.ch = int'(ev_ch); e.rise = int'(ev_rise); e.pc = pc;
            got_q.push_back(e);
            $display("pc=%0d transfer ch=%0d rise=%0d", pc, e.ch, e.rise);
        end
        if (ev_valid) valid_cycles++;
        if (ev_overflow) ovf_cnt++;
        @(posedge clk);
        @(negedge clk);
        pc++;
        if (pc % TICK_DIV == 0) model_tick();
        if (pc % TICK_DIV == 4) check($sformatf("debounced@%0d", pc), 32'(debounced), 32'(model_levels()));
    endtask

    // One full tick period with new button levels applied mid-period.
    task automatic tick_period(input logic [NUM_CH-1:0] b);
        buttons = b;
        repeat (TICK_DIV) step();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        pc = 0;
        model_reset();
        got_q.delete();
        exp_q.delete();
        valid_cycles = 0;
        ovf_cnt = 0;
        repeat (4) step();
    endtask

    // Per-channel comparison of logged transfers against the model.
    task automatic compare_events(input string tag);
        check({tag, "_total"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int c = 0; c < NUM_CH; c++) begin
            int gl[$];
            int el[$];
            foreach (got_q[i]) if (got_q[i].ch == c) gl.push_back(got_q[i].rise);
            foreach (exp_q[i]) if (exp_q[i].ch == c) el.push_back(exp_q[i].rise);
            check($sformatf("%s_ch%0d_n", tag, c), 32'(gl.size()), 32'(el.size()));
            for (int i = 0; i < gl.size() && i < el.size(); i++)
                check($sformatf("%s_ch%0d_rise%0d", tag, c, i), 32'(gl[i]), 32'(el[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [NUM_CH-1:0] nb;

        // Power-up reset.
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_debounced", 32'(debounced), 32'd0);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_ch", 32'(ev_ch), 32'd0);
        check("rst_rise", 32'(ev_rise), 32'd0);
        check("rst_ovf", 32'(ev_overflow), 32'd0);
        release_reset();

        // Idle with all buttons released.
        ev_ready = 1'b1;
        repeat (25) tick_period(3'b000);
        check("idle_events", 32'(got_q.size()), 32'd0);
        check("idle_valid_cycles", 32'(valid_cycles), 32'd0);

        // Clean press on channel 1: level changes on the 4th tick scan.
        repeat (3) tick_period(3'b010);
        check("press_before_4th", 32'(debounced), 32'b000);
        tick_period(3'b010);
        check("press_at_4th", 32'(debounced), 32'b010);
        repeat (2) tick_period(3'b010);
        check("press_n", 32'(got_q.size()), 32'd1);
        compare_events("press");
        repeat (6) tick_period(3'b000);
        compare_events("release1");

        // Bounce on channel 0 every tick: no level change, no events.
        ovf_cnt = 0;
        for (int i = 0; i < 12; i++) tick_period((i % 2 == 0) ? 3'b001 : 3'b000);
        repeat (6) tick_period(3'b000);
        check("bounce_deb0", 32'(debounced[0]), 32'd0);
        check("bounce_events", 32'(got_q.size()), 32'd0);
        check("bounce_ovf", 32'(ovf_cnt), 32'd0);
        compare_events("bounce");

        // Arbitration: all pressed together while the consumer stalls.
        ev_ready = 1'b0;
        repeat (5) tick_period(3'b111);
        for (int i = 0; i < 56; i++) begin
            check("arb_hold_valid", 32'(ev_valid), 32'd1);
            check("arb_hold_ch", 32'(ev_ch), 32'd0);
            check("arb_hold_rise", 32'(ev_rise), 32'd1);
            step();
        end
        ev_ready = 1'b1;
        repeat (8) step();
        check("arb_n", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            check($sformatf("arb_ch%0d", i), 32'(got_q[i].ch), 32'(i));
            check($sformatf("arb_rise%0d", i), 32'(got_q[i].rise), 32'd1);
            check($sformatf("arb_cycle%0d", i), 32'(got_q[i].pc), 32'(got_q[0].pc + i));
        end
        check("arb_drained", 32'(ev_valid), 32'd0);
        got_q.delete();
        exp_q.delete();
        repeat (5) tick_period(3'b000);
        compare_events("arb_release");

        // Overflow: ch0 occupies the output, ch2 posts twice unconsumed.
        ev_ready = 1'b0;
        ovf_cnt = 0;
        repeat (5) tick_period(3'b001);
        repeat (5) tick_period(3'b101);
        check("ovf_none_yet", 32'(ovf_cnt), 32'd0);
        repeat (5) tick_period(3'b001);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        ev_ready = 1'b1;
        repeat (8) step();
        check("ovf_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check("ovf_ev0_ch", 32'(got_q[0].ch), 32'd0);
            check("ovf_ev0_rise", 32'(got_q[0].rise), 32'd1);
            check("ovf_ev1_ch", 32'(got_q[1].ch), 32'd2);
            check("ovf_ev1_rise", 32'(got_q[1].rise), 32'd0);
        end
        got_q.delete();
        exp_q.delete();

        // Asynchronous reset in the middle of a scan pass with an event held.
        ev_ready = 1'b0;
        repeat (5) tick_period(3'b010);
        repeat (5) step();     // now one cycle into the scan pass
        check("midscan_valid_pre", 32'(ev_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("midscan_debounced", 32'(debounced), 32'd0);
        check("midscan_valid", 32'(ev_valid), 32'd0);
        check("midscan_ch", 32'(ev_ch), 32'd0);
        check("midscan_rise", 32'(ev_rise), 32'd0);
        check("midscan_ovf", 32'(ev_overflow), 32'd0);
        @(negedge clk);
        buttons = 3'b000;
        release_reset();
        repeat (25) tick_period(3'b000);
        check("post_rst_events", 32'(got_q.size()), 32'd0);
        check("post_rst_valid_cycles", 32'(valid_cycles), 32'd0);

        // Randomized buttons and consumer back-pressure.
        ovf_cnt = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            nb = buttons;
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 4) == 0) nb[c] = ~nb[c];
            tick_period(nb);
        end
        rand_ready = 1'b0;
        ev_ready = 1'b1;
        repeat (2) tick_period(buttons);
        compare_events("rand");
        check("rand_ovf", 32'(ovf_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Time-multiplexed debounce controller for the front-panel buttons. It samples NUM_CH raw button inputs on a shared slow tick, scanning one channel per clock through a single history-evaluation datapath. It keeps per-channel debounced levels and turns level changes into a single round-robin-arbitrated event stream with a valid/ready handshake. It sits between the pad inputs and the mixer control logic.

## Interface
- NUM_CH, 3: number of button channels (≥1)
- HIST_LEN, 8: consecutive equal samples required to change a debounced level (≥2)
- TICK_DIV, 1000: clk cycles per sample tick; must be > NUM_CH+1
- CH_W (localparam): max(1, clog2(NUM_CH))

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- buttons  in  NUM_CH  raw, asynchronous button levels
- debounced  out  NUM_CH  debounced levels
- ev_valid  out  1  event present on ev_ch/ev_rise
- ev_ready  in  1  consumer accepts event
- ev_ch  out  CH_W  channel of presented event
- ev_rise  out  1  1 = press (0→1), 0 = release (1→0)
- ev_overflow  out  1  one-cycle pulse: an unconsumed pending event was overwritten

## Operation
- Reset (async, reset=0): synchronizers, histories, debounced, prescaler, scan index, pending flags, and all outputs go to 0. The round-robin pointer goes to NUM_CH-1, so channel 0 wins the first arbitration.
- Input sync: each buttons bit passes through 2 flops before use.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1.
- Scan FSM, IDLE → SCAN:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: each cycle, hist[idx] ← {hist[idx][HIST_LEN-2:0], sync[idx]}. The new history value is evaluated in the same cycle:
    - all ones and debounced[idx]=0: set debounced[idx]; post a rise event.
    - all zeros and debounced[idx]=1: clear debounced[idx]; post a fall event.
    - otherwise: no change.
  - SCAN: idx=NUM_CH-1 → IDLE, else idx+1. Exactly one SCAN pass happens per tick.
- Posting an event on channel c: pend[c]←1, ptype[c]←edge type.
  - If pend[c] was already 1 and is not being granted this cycle: the type is overwritten and ev_overflow pulses in the following cycle.
- Output register and arbiter:
  - The output is free when ev_valid=0, or when ev_valid=1 and ev_ready=1.
  - When free, the arbiter picks the first c with pend[c]=1, searching from rr+1 with modulo-NUM_CH wrap. It loads ev_ch=c, ev_rise=ptype[c], ev_valid=1, clears pend[c], and sets rr=c.
  - When free and nothing is pending, ev_valid←0.
- Handshake: while ev_valid=1 and ev_ready=0, ev_ch/ev_rise hold stable. A transfer occurs on any cycle with both high.
- Simultaneous grant and post on the same channel: the grant takes the old entry, the new post sets pend again, and no overflow is flagged.

## Timing
- Scan of channel c occurs in cycle T+1+c, where T is the tick cycle.
- debounced[c] updates at the end of its scan cycle. pend[c] is visible the next cycle.
- ev_valid rises 2 cycles after the scan cycle at the earliest, provided the output is free.
- Back-to-back events: one transfer per cycle when ev_ready is held at 1.
- Debounce latency:
  - Input stable from tick k: debounced changes on the scan of tick k+HIST_LEN-1.
  - Add 2 cycles for the synchronizer.
- Any input bounce within HIST_LEN ticks produces no level change and no event.
- ev_overflow is never high for 2 consecutive cycles unless a distinct overwrite occurs in each.
- Reset released mid-scan: the FSM restarts in IDLE and waits for the next full tick period.

## Test plan
Parameters for all scenarios: NUM_CH=3, HIST_LEN=4, TICK_DIV=8.
- Reset: reset=0 asserted asynchronously mid-SCAN with ev_valid=1 → all outputs 0 immediately. After release, 200 cycles with buttons=0 → ev_valid stays 0, debounced=3'b000.
- Clean press: buttons[1]=1 held → debounced=3'b010 on the 4th tick scan. Then exactly one event ev_ch=1, ev_rise=1, consumed with ev_ready=1. No further events.
- Bounce: buttons[0] toggled every tick for 12 ticks, then 0 → debounced[0]=0 throughout, no events, ev_overflow never set.
- Arbitration: all 3 buttons pressed in the same cycle, ev_ready=0 for 50 cycles → ev_valid=1 with ev_ch=0 held stable. Then ev_ready=1 → events ch 0,1,2 (all ev_rise=1) on consecutive cycles, then ev_valid=0.
- Overflow: with ev_ready=0 throughout:
  - Press ch0 (occupies output).
  - Press then release ch2 (≥4 ticks each).
  - Expected: one ev_overflow pulse.
  - Then ev_ready=1: events ch0/rise=1, then ch2/rise=0, nothing else.
